bip_datapath_ext: RTL and testbench

//  Parametrised successor to the BIP accumulator datapath. Adds an extended op set,

---
 rtl/bip_pkg.sv | 30 +++
 rtl/bip_alu_ext.sv | 49 ++++
 rtl/bip_datapath_ext.sv | 212 +++++++++++++++++++++
 tb/tb_bip_datapath_ext.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared opcodes, source-select codes and FSM states for the BIP datapath.
// Optional multiplier is enabled with BIP_DATAPATH_MUL_EN.
package bip_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    localparam logic [1:0] SELA_MEM  = 2'b00;
    localparam logic [1:0] SELA_IMM  = 2'b01;
    localparam logic [1:0] SELA_ALU  = 2'b10;
    localparam logic [1:0] SELA_NONE = 2'b11;

    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/bip_alu_ext.sv
// Combinational single-cycle ALU with carry/overflow generation.
// wr is low for opcodes this ALU does not complete in one cycle.
module bip_alu_ext
    import bip_pkg::*;
#(
    parameter int DATA_LENGTH = 16
) (
    input  logic [DATA_LENGTH-1:0] a,
    input  logic [DATA_LENGTH-1:0] b,
    input  logic [3:0]             op,
    output logic [DATA_LENGTH-1:0] res,
    output logic                   c,
    output logic                   v,
    output logic                   wr
);

    localparam int M = DATA_LENGTH - 1;

    logic [DATA_LENGTH:0] sum;
    logic [DATA_LENGTH:0] dif;

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        res = a;
        c   = 1'b0;
        v   = 1'b0;
        wr  = 1'b1;
        unique case (op)
            OP_ADD: begin
                res = sum[M:0];
                c   = sum[DATA_LENGTH];
                v   = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                res = dif[M:0];
                c   = dif[DATA_LENGTH];
                v   = (a[M] != b[M]) && (dif[M] != a[M]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            default: wr = 1'b0;
        endcase
    end

endmodule

// File: rtl/bip_datapath_ext.sv
// BIP accumulator datapath with status flags and a serial shift/multiply unit.
// Define BIP_DATAPATH_MUL_EN to build the signed shift-add multiplier.
module bip_datapath_ext
    import bip_pkg::*;
#(
    parameter int DATA_LENGTH     = 16,
    parameter int IMM_DATA_LENGTH = 11,
    parameter int SHAMT_LENGTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IMM_DATA_LENGTH-1:0] imm_operand,
    input  logic [DATA_LENGTH-1:0]     data_from_memory,
    input  logic [1:0]                 SelA,
    input  logic                       SelB,
    input  logic                       WrAcc,
    input  logic [3:0]                 Op,
    output logic [DATA_LENGTH-1:0]     out_accumulator,
    output logic                       flag_z,
    output logic                       flag_n,
    output logic                       flag_c,
    output logic                       flag_v,
    output logic                       busy,
    output logic                       done
);

    localparam int M  = DATA_LENGTH - 1;
    localparam int LG = $clog2(DATA_LENGTH + 1);
    localparam int CW = (SHAMT_LENGTH > LG) ? SHAMT_LENGTH : LG;

    state_t state_q, state_d;

    logic [DATA_LENGTH-1:0] acc_q, imm_sext, b_val;
    logic [DATA_LENGTH-1:0] alu_res, sh_val, acc_nx, mul_res;
    logic [3:0]             op_q;
    logic [CW-1:0]          cnt_q, cnt_ld;
    logic z_q, n_q, c_q, v_q;
    logic alu_c, alu_v, alu_wr, sh_c, mul_op, mul_v;
    logic accept, start, is_multi, last;

    assign imm_sext = {{(DATA_LENGTH-IMM_DATA_LENGTH){imm_operand[IMM_DATA_LENGTH-1]}},
                       imm_operand};
    assign b_val    = (SelB == SELB_IMM) ? imm_sext : data_from_memory;

    bip_alu_ext #(.DATA_LENGTH(DATA_LENGTH)) u_alu (
        .a   (acc_q),
        .b   (b_val),
        .op  (Op),
        .res (alu_res),
        .c   (alu_c),
        .v   (alu_v),
        .wr  (alu_wr)
    );

    always_comb begin
        is_multi = 1'b0;
        unique case (Op)
            OP_SHL, OP_SHR, OP_SRA: is_multi = 1'b1;
`ifdef BIP_DATAPATH_MUL_EN
            OP_MUL: is_multi = 1'b1;
`endif
            default: ;
        endcase
    end

    assign busy   = (state_q == BUSY);
    assign done   = (state_q == DONE);
    assign accept = WrAcc && !busy;
    assign start  = accept && (SelA == SELA_ALU) && is_multi;
    assign last   = (cnt_q <= CW'(1));
    assign cnt_ld = (Op == OP_MUL) ? CW'(DATA_LENGTH)
                                   : CW'(b_val[SHAMT_LENGTH-1:0]);

    always_comb begin
        sh_val = acc_q;
        sh_c   = 1'b0;
        unique case (op_q)
            OP_SHL: begin
                sh_val = {acc_q[M-1:0], 1'b0};
                sh_c   = acc_q[M];
            end
            OP_SHR: begin
                sh_val = {1'b0, acc_q[M:1]};
                sh_c   = acc_q[0];
            end
            OP_SRA: begin
                sh_val = {acc_q[M], acc_q[M:1]};
                sh_c   = acc_q[0];
            end
            default: ;
        endcase
    end

`ifdef BIP_DATAPATH_MUL_EN
    localparam int PW = 2 * DATA_LENGTH;

    logic [PW-1:0]          mcand_q, prod_q, addend, prod_nx;
    logic [DATA_LENGTH-1:0] mplier_q;

    // The multiplier MSB carries negative weight, so the final step subtracts.
    assign mul_op  = (op_q == OP_MUL);
    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign prod_nx = last ? prod_q - addend : prod_q + addend;
    assign mul_res = prod_nx[M:0];
    assign mul_v   = !((&prod_nx[PW-1:M]) || !(|prod_nx[PW-1:M]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else if (start) begin
            mcand_q  <= {{DATA_LENGTH{acc_q[M]}}, acc_q};
            mplier_q <= b_val;
            prod_q   <= '0;
        end else if (busy && mul_op) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            prod_q   <= prod_nx;
        end
    end
`else
    assign mul_op  = 1'b0;
    assign mul_res = '0;
    assign mul_v   = 1'b0;
`endif

    always_comb begin
        if (mul_op)
            acc_nx = last ? mul_res : acc_q;
        else
            acc_nx = (cnt_q != '0) ? sh_val : acc_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? BUSY : IDLE;
            BUSY:    state_d = last ? DONE : BUSY;
            DONE:    state_d = start ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            op_q  <= OP_ADD;
            cnt_q <= '0;
        end else if (busy) begin
            acc_q <= acc_nx;
            z_q   <= (acc_nx == '0);
            n_q   <= acc_nx[M];
            if (cnt_q != '0)
                cnt_q <= cnt_q - CW'(1);
            if (mul_op) begin
                if (last) begin
                    c_q <= 1'b0;
                    v_q <= mul_v;
                end
            end else if (cnt_q != '0) begin
                c_q <= sh_c;
            end
        end else if (start) begin
            op_q  <= Op;
            cnt_q <= cnt_ld;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else if (accept) begin
            unique case (SelA)
                SELA_MEM: begin
                    acc_q <= data_from_memory;
                    z_q   <= (data_from_memory == '0);
                    n_q   <= data_from_memory[M];
                end
                SELA_IMM: begin
                    acc_q <= imm_sext;
                    z_q   <= (imm_sext == '0);
                    n_q   <= imm_sext[M];
                end
                SELA_ALU: begin
                    if (alu_wr) begin
                        acc_q <= alu_res;
                        z_q   <= (alu_res == '0);
                        n_q   <= alu_res[M];
                        c_q   <= alu_c;
                        v_q   <= alu_v;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_accumulator = acc_q;
    assign flag_z          = z_q;
    assign flag_n          = n_q;
    assign flag_c          = c_q;
    assign flag_v          = v_q;

endmodule

// File: tb/tb_bip_datapath_ext.sv
// Directed bench for bip_datapath_ext with an arithmetic reference model.
// Build with BIP_DATAPATH_MUL_EN to exercise the multiplier path.
module tb_bip_datapath_ext;
    import bip_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] imm_operand = '0;
    logic [15:0] data_from_memory = '0;
    logic [1:0]  SelA = SELA_NONE;
    logic        SelB = 1'b0;
    logic        WrAcc = 1'b0;
    logic [3:0]  Op = OP_ADD;
    logic [15:0] out_accumulator;
    logic        flag_z, flag_n, flag_c, flag_v, busy, done;

    int checks = 0;
    int errors = 0;

    bip_datapath_ext dut (
        .clk              (clk),
        .reset            (reset),
        .imm_operand      (imm_operand),
        .data_from_memory (data_from_memory),
        .SelA             (SelA),
        .SelB             (SelB),
        .WrAcc            (WrAcc),
        .Op               (Op),
        .out_accumulator  (out_accumulator),
        .flag_z           (flag_z),
        .flag_n           (flag_n),
        .flag_c           (flag_c),
        .flag_v           (flag_v),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: results computed per operation, not per cycle.
    logic [15:0] m_acc, p_acc;
    logic        m_z, m_n, m_c, m_v, m_done, p_c, p_v;
    int          m_busy_left;

    task automatic m_finish_alu(input int r, input logic c, input logic v);
        m_acc = r[15:0];
        m_z   = (m_acc == 16'h0);
        m_n   = m_acc[15];
        m_c   = c;
        m_v   = v;
    endtask

    task automatic m_start(input int cycles, input int r, input logic c,
                           input logic v);
        m_busy_left = cycles;
        p_acc       = r[15:0];
        p_c         = c;
        p_v         = v;
    endtask

    task automatic m_alu(input logic [15:0] b, input logic [3:0] op);
        int ua, ub, sa, sb, r, n, t;
        ua = m_acc;
        ub = b;
        sa = $signed(m_acc);
        sb = $signed(b);
        n  = b[3:0];
        case (op)
            OP_ADD: begin
                r = ua + ub;
                m_finish_alu(r, r > 65535, (sa + sb > 32767) || (sa + sb < -32768));
            end
            OP_SUB: begin
                r = ua - ub;
                m_finish_alu(r, ua < ub, (sa - sb > 32767) || (sa - sb < -32768));
            end
            OP_AND: m_finish_alu(ua & ub, 1'b0, 1'b0);
            OP_OR:  m_finish_alu(ua | ub, 1'b0, 1'b0);
            OP_XOR: m_finish_alu(ua ^ ub, 1'b0, 1'b0);
            OP_NOT: m_finish_alu(~ua, 1'b0, 1'b0);
            OP_SHL: begin
                r = ua << n;
                m_start((n == 0) ? 1 : n, r, (n != 0) && r[16], 1'b0);
            end
            OP_SHR: begin
                t = (n == 0) ? 0 : ((ua >> (n - 1)) & 1);
                m_start((n == 0) ? 1 : n, ua >> n, t[0], 1'b0);
            end
            OP_SRA: begin
                t = (n == 0) ? 0 : ((sa >>> (n - 1)) & 1);
                m_start((n == 0) ? 1 : n, sa >>> n, t[0], 1'b0);
            end
`ifdef BIP_DATAPATH_MUL_EN
            OP_MUL: begin
                r = sa * sb;
                m_start(16, r, 1'b0, (r > 32767) || (r < -32768));
            end
`endif
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        logic [15:0] bsrc;
        logic [15:0] sx;
        if (!reset) begin
            m_acc = '0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
            m_done = 0; m_busy_left = 0;
        end else begin
            sx   = {{5{imm_operand[10]}}, imm_operand};
            bsrc = SelB ? sx : data_from_memory;
            m_done = 1'b0;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_acc  = p_acc;
                    m_z    = (p_acc == 16'h0);
                    m_n    = p_acc[15];
                    m_c    = p_c;
                    m_v    = p_v;
                    m_done = 1'b1;
                end
            end else if (WrAcc) begin
                case (SelA)
                    SELA_MEM: begin
                        m_acc = data_from_memory;
                        m_z = (m_acc == 0); m_n = m_acc[15];
                    end
                    SELA_IMM: begin
                        m_acc = sx;
                        m_z = (m_acc == 0); m_n = m_acc[15];
                    end
                    SELA_ALU: m_alu(bsrc, Op);
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy_left > 0);
        chk("done", done, m_done);
        if (m_busy_left == 0) begin
            chk("acc", out_accumulator, m_acc);
            chk("flag_z", flag_z, m_z);
            chk("flag_n", flag_n, m_n);
            chk("flag_c", flag_c, m_c);
            chk("flag_v", flag_v, m_v);
        end
    end

    task automatic issue(input logic [1:0] sa, input logic sb,
                         input logic [3:0] op, input logic [10:0] imm,
                         input logic [15:0] mem);
        SelA = sa; SelB = sb; Op = op;
        imm_operand = imm; data_from_memory = mem;
        WrAcc = 1'b1;
        @(posedge clk);
        #1;
        WrAcc = 1'b0;
        SelA = SELA_NONE;
    endtask

    task automatic wait_done(input string nm, input int max, output int ncyc);
        bit got;
        got = 0;
        ncyc = 0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else if (busy) ncyc++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_done required=done", nm);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        chk(nm, act, exp);
    endtask

    initial begin
        int nc;
        repeat (2) @(posedge clk);
        #1;
        lit("reset acc", out_accumulator, 16'h0);
        lit("reset busy", busy, 0);
        reset = 1'b1;

        issue(SELA_IMM, 0, OP_ADD, 11'h7FF, 16'h0);
        @(negedge clk);
        lit("t1 acc", out_accumulator, 16'hFFFF);
        lit("t1 n", flag_n, 1);
        lit("t1 model acc", m_acc, 16'hFFFF);

        issue(SELA_MEM, 0, OP_ADD, 0, 16'h7FFF);
        issue(SELA_ALU, SELB_MEM, OP_ADD, 0, 16'h0001);
        @(negedge clk);
        lit("t2 add acc", out_accumulator, 16'h8000);
        lit("t2 add v", flag_v, 1);
        lit("t2 model v", m_v, 1);
        lit("t2 add c", flag_c, 0);
        issue(SELA_ALU, SELB_MEM, OP_SUB, 0, 16'h8000);
        @(negedge clk);
        lit("t2 sub acc", out_accumulator, 16'h0);
        lit("t2 sub z", flag_z, 1);

        issue(SELA_ALU, SELB_MEM, OP_SUB, 0, 16'h0001);
        issue(SELA_ALU, SELB_MEM, OP_AND, 0, 16'h0FF0);
        issue(SELA_ALU, SELB_IMM, OP_XOR, 11'h00F, 16'h0);
        issue(SELA_ALU, SELB_IMM, OP_NOT, 0, 16'h0);
        issue(SELA_ALU, SELB_IMM, 4'b1100, 11'h123, 16'h0);
        issue(SELA_NONE, 0, OP_ADD, 11'h001, 16'h0);
        @(negedge clk);
        lit("logic acc", out_accumulator, 16'hF000);

        issue(SELA_MEM, 0, OP_ADD, 0, 16'h8001);
        issue(SELA_ALU, SELB_IMM, OP_SHL, 11'd3, 16'h0);
        wait_done("t3 shl", 40, nc);
        lit("t3 shl cycles", nc, 3);
        lit("t3 shl acc", out_accumulator, 16'h0008);
        lit("t3 shl c", flag_c, 0);
        issue(SELA_MEM, 0, OP_ADD, 0, 16'h8000);
        issue(SELA_ALU, SELB_IMM, OP_SRA, 11'd15, 16'h0);
        wait_done("t3 sra", 40, nc);
        lit("t3 sra cycles", nc, 15);
        lit("t3 sra acc", out_accumulator, 16'hFFFF);
        lit("t3 model acc", m_acc, 16'hFFFF);

        issue(SELA_ALU, SELB_IMM, OP_SHL, 11'd0, 16'h0);
        wait_done("shamt0", 40, nc);
        lit("shamt0 cycles", nc, 1);
        lit("shamt0 acc", out_accumulator, 16'hFFFF);

        issue(SELA_MEM, 0, OP_ADD, 0, 16'h0005);
        issue(SELA_ALU, SELB_IMM, OP_SHL, 11'd4, 16'h0);
        issue(SELA_IMM, 0, OP_ADD, 11'd7, 16'h0);
        wait_done("t4 stall", 40, nc);
        lit("t4 stall acc", out_accumulator, 16'h0050);

        issue(SELA_MEM, 0, OP_ADD, 0, 16'h1234);
        issue(SELA_ALU, SELB_IMM, OP_SHL, 11'd10, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        lit("t4 rst acc", out_accumulator, 16'h0);
        lit("t4 rst busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        issue(SELA_IMM, 0, OP_ADD, 11'd3, 16'h0);
        issue(SELA_ALU, SELB_IMM, OP_MUL, 11'h7FE, 16'h0);
`ifdef BIP_DATAPATH_MUL_EN
        wait_done("t5 mul", 40, nc);
        lit("t5 mul cycles", nc, 16);
        lit("t5 mul acc", out_accumulator, 16'hFFFA);
        lit("t5 mul v", flag_v, 0);
        issue(SELA_MEM, 0, OP_ADD, 0, 16'h4000);
        issue(SELA_ALU, SELB_IMM, OP_MUL, 11'd4, 16'h0);
        wait_done("t5 mul ovf", 40, nc);
        lit("t5 ovf v", flag_v, 1);
        lit("t5 ovf acc", out_accumulator, 16'h0000);
`else
        @(negedge clk);
        lit("t5 nomul busy", busy, 0);
        lit("t5 nomul acc", out_accumulator, 16'h0003);
`endif

        issue(SELA_MEM, 0, OP_ADD, 0, 16'h00F0);
        issue(SELA_ALU, SELB_IMM, OP_SHR, 11'd2, 16'h0);
        wait_done("t6 first", 40, nc);
        issue(SELA_ALU, SELB_IMM, OP_SHR, 11'd1, 16'h0);
        @(negedge clk);
        lit("t6 rebusy", busy, 1);
        wait_done("t6 second", 40, nc);
        lit("t6 acc", out_accumulator, 16'h001E);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
